// File: rtl/rv32_multicycle_core.sv
// rv32_multicycle_core: multi-cycle RV32I core with one shared req/ready memory port.
// Define RV32_MC_MISALIGN_TRAP_EN to halt on misaligned LW/SW and branch/jump targets.
module rv32_multicycle_core #(
    parameter int          ADDR_W   = 7,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic              halted,
    output logic [31:0]       pc_out
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    state_t state, state_n;
    logic [31:0] pc, ir, a, b, imm, aluout, mdr;
    logic [31:0] regs [32];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [4:0] rd;
    logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, is_fence, is_sys;
    logic illegal, ebreak, alt, taken, trap;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel, op_x, op_y, alu_raw, alu_res, wb_val;

    function automatic logic [31:0] alu(input logic [2:0] f, input logic sub, input logic [31:0] x,
                                        input logic [31:0] y);
        logic signed [31:0] sra;
        sra = $signed(x) >>> y[4:0];
        case (f)
            3'b000:  alu = sub ? x - y : x + y;
            3'b001:  alu = x << y[4:0];
            3'b010:  alu = {31'b0, $signed(x) < $signed(y)};
            3'b011:  alu = {31'b0, x < y};
            3'b100:  alu = x ^ y;
            3'b101:  alu = sub ? sra : x >> y[4:0];
            3'b110:  alu = x | y;
            default: alu = x & y;
        endcase
    endfunction

    assign opc      = ir[6:0];
    assign f3       = ir[14:12];
    assign rd       = ir[11:7];
    assign is_lui   = opc == 7'h37;
    assign is_auipc = opc == 7'h17;
    assign is_jal   = opc == 7'h6F;
    assign is_jalr  = opc == 7'h67;
    assign is_br    = opc == 7'h63;
    assign is_ld    = opc == 7'h03;
    assign is_st    = opc == 7'h23;
    assign is_opi   = opc == 7'h13;
    assign is_op    = opc == 7'h33;
    assign is_fence = opc == 7'h0F;
    assign is_sys   = opc == 7'h73;
    assign illegal  = !(is_lui || is_auipc || is_jal || is_jalr || is_br || is_ld || is_st ||
                        is_opi || is_op || is_fence || is_sys);
    assign ebreak   = is_sys && ir[31:20] == 12'd1;

    assign imm_i   = {{20{ir[31]}}, ir[31:20]};
    assign imm_s   = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b   = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u   = {ir[31:12], 12'b0};
    assign imm_j   = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign imm_sel = (is_lui || is_auipc) ? imm_u : is_jal ? imm_j : is_br ? imm_b : is_st ? imm_s : imm_i;

    // Jumps and branches reuse the ALU adder for their target address.
    assign op_x    = (is_auipc || is_jal || is_br) ? pc : is_lui ? 32'b0 : a;
    assign op_y    = is_op ? b : imm;
    assign alt     = is_op ? ir[30] : (is_opi && f3 == 3'b101 && ir[30]);
    assign alu_raw = alu((is_op || is_opi) ? f3 : 3'b000, alt, op_x, op_y);
    assign alu_res = is_jalr ? {alu_raw[31:1], 1'b0} : alu_raw;
    assign taken   = f3[2] ? ((f3[1] ? a < b : $signed(a) < $signed(b)) ^ f3[0]) : ((a == b) ^ f3[0]);
    assign wb_val  = is_ld ? mdr : (is_jal || is_jalr) ? pc + 32'd4 : aluout;

`ifdef RV32_MC_MISALIGN_TRAP_EN
    assign trap = (is_ld || is_st || is_jal || is_jalr || (is_br && taken)) && alu_res[1:0] != 2'b00;
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            FETCH:   state_n = mem_ready ? DECODE : FETCH;
            DECODE:  state_n = (illegal || ebreak) ? HALT : EXEC;
            EXEC:    state_n = trap ? HALT : (is_ld || is_st) ? MEM :
                               (is_br || is_fence || is_sys) ? FETCH : WB;
            MEM:     state_n = !mem_ready ? MEM : is_st ? FETCH : WB;
            WB:      state_n = FETCH;
            default: state_n = HALT;
        endcase
    end

    assign mem_req   = !rst && (state == FETCH || state == MEM);
    assign mem_we    = !rst && state == MEM && is_st;
    assign mem_addr  = {(state == MEM ? aluout[ADDR_W-1:2] : pc[ADDR_W-1:2]), 2'b00};
    assign mem_wdata = b;
    assign retire    = !rst && ((state == EXEC && state_n == FETCH) ||
                                (state == MEM && is_st && mem_ready) || state == WB);
    assign halted    = state == HALT || (state == DECODE && (illegal || ebreak));
    assign pc_out    = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            imm    <= '0;
            aluout <= '0;
            mdr    <= '0;
        end else begin
            case (state)
                FETCH:  if (mem_ready) ir <= mem_rdata;
                DECODE: begin
                    a   <= regs[ir[19:15]];
                    b   <= regs[ir[24:20]];
                    imm <= imm_sel;
                end
                EXEC: begin
                    aluout <= alu_res;
                    if (state_n == FETCH) pc <= (is_br && taken) ? alu_res : pc + 32'd4;
                end
                MEM: if (mem_ready) begin
                    mdr <= mem_rdata;
                    if (is_st) pc <= pc + 32'd4;
                end
                WB:      pc <= (is_jal || is_jalr) ? aluout : pc + 32'd4;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (state == WB && rd != 5'd0) begin
            regs[rd] <= wb_val;
        end
    end
endmodule

// File: tb/tb_rv32_multicycle_core.sv
// tb_rv32_multicycle_core: directed program run against a wait-state memory model.
module tb_rv32_multicycle_core;
    logic        clk = 0, rst = 1;
    logic        mem_req, mem_we, mem_ready, retire, halted, slow;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata, pc_out;
    logic [31:0] mem [32];
    logic [31:0] prog [32];
    logic [1:0]  wcnt;
    int checks = 0, errors = 0, cyc = 0, nret = 0, nrd = 0, nst = 0;
    int          ret_cyc [64];
    logic [6:0]  rd_log [64];
    logic [6:0]  st_a [16];
    logic [31:0] st_d [16];
    logic        pend = 0;
    logic [40:0] prev = '0;
    int          lat [16] = '{4, 4, 8, 9, 3, 3, 6, 4, 4, 6, 6, 4, 4, 6, 6, 6};
    logic [6:0]  exp_rd [18] = '{7'h10, 7'h14, 7'h18, 7'h1C, 7'h70, 7'h20, 7'h28, 7'h2C, 7'h30,
                                 7'h3C, 7'h40, 7'h44, 7'h48, 7'h4C, 7'h50, 7'h54, 7'h58, 7'h5C};
    logic [6:0]  exp_sa [7] = '{7'h70, 7'h74, 7'h78, 7'h7C, 7'h60, 7'h64, 7'h68};
    logic [31:0] exp_sd [7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h34, 32'h0, 32'h36, 32'hFFFF_FFFF, 32'h0};

    rv32_multicycle_core #(.ADDR_W(7), .RESET_PC(32'h10)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .retire(retire), .halted(halted), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    // Accesses to 0x18, 0x1C and the data area at 0x60+ take two wait states.
    assign slow      = mem_addr == 7'h18 || mem_addr == 7'h1C || mem_addr >= 7'h60;
    assign mem_ready = mem_req && wcnt == (slow ? 2'd2 : 2'd0);
    assign mem_rdata = mem[mem_addr[6:2]];

    always @(posedge clk) begin
        if (rst || !mem_req || mem_ready) wcnt <= 2'd0;
        else wcnt <= wcnt + 2'd1;
    end

    always @(posedge clk) begin
        if (rst) mem = prog;
        else if (mem_req && mem_we && mem_ready) mem[mem_addr[6:2]] = mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] imm, rs1, f3, rd, op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, rs2, rs1);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, rs2, rs1, f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction
    function automatic logic [31:0] enc_r(input logic [31:0] f7, rs2, rs1, f3, rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (pend) chk("hold_stable", {mem_req, mem_we, mem_wdata, mem_addr}, prev);
            pend = mem_req && !mem_ready;
            prev = {mem_req, mem_we, mem_wdata, mem_addr};
            if (retire && nret < 64) begin
                ret_cyc[nret] = cyc;
                nret++;
            end
            if (mem_req && mem_ready && !mem_we && nrd < 64) begin
                rd_log[nrd] = mem_addr;
                nrd++;
            end
            if (mem_req && mem_ready && mem_we && nst < 16) begin
                st_a[nst] = mem_addr;
                st_d[nst] = mem_wdata;
                nst++;
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) prog[i] = (i >= 24) ? 32'hDEAD_BEEF : 32'h0;
        prog[4]  = enc_i(5, 0, 0, 1, 7'h13);
        prog[5]  = enc_i(-7, 1, 0, 2, 7'h13);
        prog[6]  = enc_s(32'h70, 2, 0);
        prog[7]  = enc_i(32'h70, 0, 2, 3, 7'h03);
        prog[8]  = enc_b(8, 1, 2, 4);
        prog[9]  = enc_i(1, 0, 0, 5, 7'h13);
        prog[10] = enc_b(8, 1, 2, 6);
        prog[11] = enc_s(32'h74, 3, 0);
        prog[12] = enc_j(12, 1);
        prog[13] = enc_i(1, 0, 0, 5, 7'h13);
        prog[14] = enc_i(1, 0, 0, 5, 7'h13);
        prog[15] = enc_i(9, 0, 0, 0, 7'h13);
        prog[16] = enc_s(32'h78, 1, 0);
        prog[17] = enc_s(32'h7C, 0, 0);
        prog[18] = enc_r(32'h20, 2, 1, 0, 6);
        prog[19] = enc_i(32'h401, 2, 5, 7, 7'h13);
        prog[20] = enc_s(32'h60, 6, 0);
        prog[21] = enc_s(32'h64, 7, 0);
        prog[22] = enc_s(32'h68, 5, 0);
        prog[23] = 32'h0000_007F;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_retire", retire, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc_out, 32'h10);
        rst = 0;
        @(negedge clk);
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, 7'h10);
        chk("first_we", mem_we, 0);
        chk("first_pc", pc_out, 32'h10);
        for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
        chk("halt_reached", halted, 1);
        chk("n_retire", nret, 16);
        chk("n_reads", nrd, 18);
        chk("n_stores", nst, 7);
        for (int i = 0; i < 16 && i < nret; i++)
            chk($sformatf("retire_gap%0d", i), (i == 0) ? ret_cyc[0] : ret_cyc[i] - ret_cyc[i-1], lat[i]);
        for (int i = 0; i < 18 && i < nrd; i++)
            chk($sformatf("read_addr%0d", i), rd_log[i], exp_rd[i]);
        for (int i = 0; i < 7 && i < nst; i++) begin
            chk($sformatf("store_addr%0d", i), st_a[i], exp_sa[i]);
            chk($sformatf("store_data%0d", i), st_d[i], exp_sd[i]);
        end
        repeat (4) begin
            @(negedge clk);
            chk("halt_quiet", {halted, mem_req, retire}, 3'b100);
        end
        chk("halt_pc", pc_out, 32'h5C);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
